// File: rtl/array_pkg.sv
// Shared widths and FSM encoding for the array_fetch BRAM read streamer.
package array_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer catching registered BRAM read data; the head entry is
// held in its own register so stream outputs never see rd_data combinationally.
module fetch_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head,
  output logic         valid
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= din;
          else               tail_q <= din;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) head_q <= tail_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the incoming word lands behind whatever remains.
          if (cnt_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= din;
          end else begin
            head_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = cnt_q;
  assign head  = head_q;
  assign valid = (cnt_q != 2'd0);

endmodule

// File: rtl/array_fetch.sv
// Streaming read controller draining one BRAM read port into a valid/ready stream.
// Optional build macro: ARRAY_FETCH_STRIDE_EN adds a latched address stride port.
//
//   state   | meaning
//   S_IDLE  | waiting for start; zero-length start only pulses done
//   S_RUN   | issuing reads while the skid buffer has room
//   S_DRAIN | all reads issued, waiting for the last word to be accepted
module array_fetch
  import array_pkg::*;
#(
  parameter int ADDR_W = array_pkg::ADDR_W,
  parameter int DATA_W = array_pkg::DATA_W,
  parameter int LEN_W  = array_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
`ifdef ARRAY_FETCH_STRIDE_EN
  input  logic [3:0]        stride,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  fetch_state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_inc;
  logic [LEN_W-1:0]  remain_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              accept;
  logic              issue;
  logic              pop;
  logic              done_nx;
  logic [2:0]        occ;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic              fifo_valid;

  assign pop = fifo_valid & out_ready;
  // Slots already claimed once this cycle's pop and any in-flight read settle.
  assign occ = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

`ifdef ARRAY_FETCH_STRIDE_EN
  logic [3:0] stride_q;
  logic [3:0] stride_eff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      stride_q <= 4'd0;
    else if (accept) stride_q <= stride;
  end

  assign stride_eff = (stride_q == 4'd0) ? 4'd1 : stride_q;
  assign addr_inc   = {{(ADDR_W-4){1'b0}}, stride_eff};
`else
  assign addr_inc = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    issue    = 1'b0;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_nx = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (occ < 3'd2) begin
          issue = 1'b1;
          if (remain_q == LEN_W'(1)) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && fifo_head[DATA_W]) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done            <= 1'b0;
    end else begin
      done            <= done_nx;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remain_q == LEN_W'(1));
      if (accept) begin
        addr_q   <= base_addr;
        remain_q <= length;
      end else if (issue) begin
        addr_q   <= addr_q + addr_inc;
        remain_q <= remain_q - LEN_W'(1);
      end
    end
  end

  fetch_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .din   ({inflight_last_q, rd_data}),
    .pop   (pop),
    .count (fifo_count),
    .head  (fifo_head),
    .valid (fifo_valid)
  );

  assign rd_addr   = addr_q;
  assign out_data  = fifo_head[DATA_W-1:0];
  assign out_valid = fifo_valid;
  assign out_last  = fifo_valid & fifo_head[DATA_W];
  assign busy      = (state != S_IDLE);

endmodule
